// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver state encoding, oversampling
// constants and small helpers used by both the receiver and the baud divider.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int SAMPLE_LO  = 7;
   localparam int SAMPLE_HI  = 9;

   // Clocks per oversample tick, rounded to nearest.
   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return (clk_freq + (baud_rate * OVERSAMPLE) / 2) / (baud_rate * OVERSAMPLE);
   endfunction

   function automatic logic vote3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every DIV clocks, held at phase 0
// while clr_i is high so the first tick lands a full period after release.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;
   logic          at_top;

   assign at_top = (cnt == CW'(DIV - 1));
   assign tick_o = at_top & ~clr_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt <= '0;
      end else if (clr_i || at_top) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 voting around mid-bit and a
// four-phase valid/ready byte output with framing-error and overrun pulses.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           rx_i,
   output logic [7:0]     data_o,
   output logic           data_vld_o,
   input  logic           data_rdy_i,
   output logic           frame_err_o,
   output logic           overrun_o,
   output uart_rx_state_t dbg_state_o
);

   // Handshake: data_vld_o rises only when data_rdy_i is low; it then holds with
   // data_o stable until data_rdy_i is sampled high, and clears on that edge.

   localparam logic [3:0] S_LO   = 4'(SAMPLE_LO);
   localparam logic [3:0] S_MID  = 4'(SAMPLE_LO + 1);
   localparam logic [3:0] S_HI   = 4'(SAMPLE_HI);
   localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

   logic           sync1, sync2;
   uart_rx_state_t state, state_nxt;
   logic [3:0]     samp;
   logic [2:0]     bit_cnt;
   logic [7:0]     shreg;
   logic           s7, s8, s9;
   logic           tick, div_clr;
   logic           shift_en, frame_done;
   logic           bit_vote, stop_vote, busy;

   uart_baud_tick #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE)
   ) u_tick (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .clr_i   (div_clr),
      .tick_o  (tick)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= rx_i;
         sync2 <= sync1;
      end
   end

   assign bit_vote  = vote3(s7, s8, s9);
   // Stop is decided at sample 9 itself, so the live sample stands in for s9.
   assign stop_vote = vote3(s7, s8, sync2);
   assign busy      = data_vld_o | data_rdy_i;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      div_clr    = 1'b0;
      shift_en   = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            div_clr = 1'b1;
            if (!sync2) state_nxt = START;
         end
         START: begin
            if (tick && samp == S_LAST) state_nxt = bit_vote ? IDLE : DATA;
         end
         DATA: begin
            if (tick && samp == S_LAST) begin
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (tick && samp == S_HI) begin
               frame_done = 1'b1;
               state_nxt  = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         samp    <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         s7      <= 1'b1;
         s8      <= 1'b1;
         s9      <= 1'b1;
      end else if (state == IDLE) begin
         samp    <= '0;
         bit_cnt <= '0;
      end else begin
         if (tick) begin
            samp <= samp + 1'b1;
            if (samp == S_LO)  s7 <= sync2;
            if (samp == S_MID) s8 <= sync2;
            if (samp == S_HI)  s9 <= sync2;
         end
         if (shift_en) begin
            shreg   <= {bit_vote, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_o      <= '0;
         data_vld_o  <= 1'b0;
         frame_err_o <= 1'b0;
         overrun_o   <= 1'b0;
      end else begin
         frame_err_o <= frame_done & ~stop_vote;
         overrun_o   <= frame_done & stop_vote & busy;
         if (frame_done && stop_vote && !busy) begin
            data_o     <= shreg;
            data_vld_o <= 1'b1;
         end else if (data_vld_o && data_rdy_i) begin
            data_vld_o <= 1'b0;
         end
      end
   end

   assign dbg_state_o = state;

endmodule
